seq_pattern_fsm: RTL and testbench

Parameterised serial pattern-detector state machine for the state-transition block library. It accepts one qualified input bit per cycle and flags every occurrence of a compile-time pattern of length PAT_W. Overlap handling and output style (Mealy or Moore) are selected by parameter. It replaces the hand-derived two-flip-flop state circuits with one generic, elaboration-computed transition function.

---
 rtl/seq_pkg.sv | 63 ++++++
 rtl/seq_pattern_next.sv | 44 ++++
 rtl/seq_pattern_fsm.sv | 67 ++++++
 tb/tb_seq_pattern_fsm.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared helpers for the pattern detector: state width and elaborated KMP tables
package seq_pkg;

  localparam int MAX_W = 16;
  localparam int TW    = 5;

  typedef logic [MAX_W:0][TW-1:0]      fail_tab_t;
  typedef logic [MAX_W:0][1:0][TW-1:0] next_tab_t;

  function automatic int state_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Bit i of the pattern in arrival order (i = 0 is received first).
  function automatic logic pat_bit(input logic [MAX_W-1:0] pattern, input int pat_w, input int i);
    logic [MAX_W-1:0] sh;
    sh = pattern >> (pat_w - 1 - i);
    return sh[0];
  endfunction

  // f[k] = longest proper prefix of the pattern that is also a suffix of its first k bits.
  function automatic fail_tab_t fail_table(input logic [MAX_W-1:0] pattern, input int pat_w);
    fail_tab_t f;
    int        k;
    int        n;
    f = '0;
    k = 0;
    for (int i = 1; i < pat_w; i++) begin
      for (int j = 0; j < MAX_W; j++)
        if (k > 0 && pat_bit(pattern, pat_w, i) != pat_bit(pattern, pat_w, k))
          k = int'(f[k[TW-1:0]]);
      if (pat_bit(pattern, pat_w, i) == pat_bit(pattern, pat_w, k))
        k++;
      n = i + 1;
      f[n[TW-1:0]] = k[TW-1:0];
    end
    return f;
  endfunction

  // Full transition function t[s][b] for states 0..pat_w-1; pat_w in the result means a hit.
  function automatic next_tab_t next_table(input logic [MAX_W-1:0] pattern, input int pat_w);
    fail_tab_t f;
    next_tab_t t;
    int        k;
    logic      bv;
    f = fail_table(pattern, pat_w);
    t = '0;
    for (int s = 0; s < pat_w; s++) begin
      for (int b = 0; b < 2; b++) begin
        bv = b[0];
        k  = s;
        for (int j = 0; j < MAX_W; j++)
          if (k > 0 && pat_bit(pattern, pat_w, k) != bv)
            k = int'(f[k[TW-1:0]]);
        if (pat_bit(pattern, pat_w, k) == bv)
          k++;
        t[s[TW-1:0]][b[0]] = k[TW-1:0];
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/seq_pattern_next.sv
// rtl/seq_pattern_next.sv - combinational next-state and hit decode from the elaborated transition table
module seq_pattern_next
  import seq_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter bit               OVERLAP = 1'b1,
  parameter bit               MOORE   = 1'b0,
  localparam int              SW      = state_w(PAT_W)
) (
  input  logic [SW-1:0] state,
  input  logic          din,
  input  logic          din_vld,
  input  logic          clr,
  output logic [SW-1:0] next_state,
  output logic          hit
);

  localparam fail_tab_t       FAIL     = fail_table(MAX_W'(PATTERN), PAT_W);
  localparam next_tab_t       NEXT     = next_table(MAX_W'(PATTERN), PAT_W);
  localparam logic [SW-1:0]   S_FULL   = SW'(PAT_W);
  localparam logic [SW-1:0]   S_RESUME = OVERLAP ? SW'(FAIL[TW'(PAT_W)]) : '0;

  logic [SW-1:0] base;
  logic [SW-1:0] adv;

  always_comb begin
    // The Moore MATCH state resumes from the post-match state before looking at din.
    base       = (state == S_FULL) ? S_RESUME : state;
    adv        = SW'(NEXT[TW'(base)][din]);
    hit        = 1'b0;
    next_state = state;
    if (clr) begin
      next_state = '0;
    end else if (din_vld) begin
      hit = (adv == S_FULL);
      if (hit)
        next_state = MOORE ? S_FULL : S_RESUME;
      else
        next_state = adv;
    end
  end

endmodule

// File: rtl/seq_pattern_fsm.sv
// rtl/seq_pattern_fsm.sv - serial pattern detector top; match counter exists only when MATCH_CNT_EN is defined
module seq_pattern_fsm
  import seq_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter bit               OVERLAP = 1'b1,
  parameter bit               MOORE   = 1'b0,
  parameter int               CNT_W   = 8,
  localparam int              SW      = state_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             din_vld,
  input  logic             din,
  output logic             match,
  output logic [SW-1:0]    state_o,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [SW-1:0] S_FULL = SW'(PAT_W);

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic          hit;

  seq_pattern_next #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP),
    .MOORE   (MOORE)
  ) u_next (
    .state      (state_q),
    .din        (din),
    .din_vld    (din_vld),
    .clr        (clr),
    .next_state (state_d),
    .hit        (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= '0;
    else
      state_q <= state_d;
  end

  assign state_o = state_q;
  assign match   = MOORE ? (state_q == S_FULL) : hit;

`ifdef MATCH_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      match_cnt <= '0;
    else if (clr)
      match_cnt <= '0;
    else if (hit && !(&match_cnt))
      match_cnt <= match_cnt + CNT_W'(1);
  end
`else
  logic unused_hit;
  assign unused_hit = hit;
  assign match_cnt  = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_fsm.sv
// tb/tb_seq_pattern_fsm.sv - scoreboard bench: four detector configurations against a history-based reference model
module tb_seq_pattern_fsm;

  localparam int          NC    = 4;
  localparam int          PAT_W = 4;
  localparam int          PAT_V = 'b1101;
  localparam logic [3:0]  OV    = 4'b0101;  // bit c: config c counts overlapping matches
  localparam logic [3:0]  MO    = 4'b1100;  // bit c: config c is Moore

  logic clk;
  logic rst_n;
  logic clr;
  logic din_vld;
  logic din;

  logic [NC-1:0] m;
  logic [2:0]    st [NC];
  logic [7:0]    cnt_a, cnt_b, cnt_c;
  logic [1:0]    cnt_d;
  logic [7:0]    cnt [NC];

  assign cnt[0] = cnt_a;
  assign cnt[1] = cnt_b;
  assign cnt[2] = cnt_c;
  assign cnt[3] = {6'b0, cnt_d};

  seq_pattern_fsm u_a (.clk(clk), .rst_n(rst_n), .clr(clr), .din_vld(din_vld), .din(din),
                       .match(m[0]), .state_o(st[0]), .match_cnt(cnt_a));
  seq_pattern_fsm #(.OVERLAP(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .clr(clr), .din_vld(din_vld), .din(din),
                       .match(m[1]), .state_o(st[1]), .match_cnt(cnt_b));
  seq_pattern_fsm #(.MOORE(1'b1)) u_c (.clk(clk), .rst_n(rst_n), .clr(clr), .din_vld(din_vld), .din(din),
                       .match(m[2]), .state_o(st[2]), .match_cnt(cnt_c));
  seq_pattern_fsm #(.MOORE(1'b1), .OVERLAP(1'b0), .CNT_W(2)) u_d (.clk(clk), .rst_n(rst_n), .clr(clr),
                       .din_vld(din_vld), .din(din), .match(m[3]), .state_o(st[3]), .match_cnt(cnt_d));

  typedef struct packed {
    logic [NC-1:0]       m;
    logic [NC-1:0][3:0]  s;
    logic [NC-1:0][7:0]  n;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: recent valid bits since the last restart, newest in bit 0.
  int hb    [NC];
  int hl    [NC];
  int mflag [NC];
  int cnt_m [NC];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cmax(input int c);
    return (c == 3) ? 3 : 255;
  endfunction

  function automatic int pref(input int c);
    for (int k = PAT_W - 1; k >= 1; k--)
      if (hl[c] >= k && (hb[c] & ((1 << k) - 1)) == (PAT_V >> (PAT_W - k)))
        return k;
    return 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      hb[c] = 0; hl[c] = 0; mflag[c] = 0; cnt_m[c] = 0;
    end
  endtask

  task automatic step(input bit c_clr, input bit c_vld, input bit c_din);
    exp_t e;
    int   nb, nl;
    bit   complete;
    @(posedge clk);
    #1;
    rst_n = 1'b1; clr = c_clr; din_vld = c_vld; din = c_din;
    for (int c = 0; c < NC; c++) begin
      nb = ((hb[c] << 1) | int'(c_din)) & ((1 << PAT_W) - 1);
      nl = (hl[c] + 1 > PAT_W) ? PAT_W : hl[c] + 1;
      complete = c_vld && !c_clr && nl == PAT_W && nb == PAT_V;
      e.m[c] = MO[c] ? (mflag[c] != 0) : complete;
      e.s[c] = (mflag[c] != 0) ? 4'(PAT_W) : 4'(pref(c));
`ifdef MATCH_CNT_EN
      e.n[c] = 8'(cnt_m[c]);
`else
      e.n[c] = 8'd0;
`endif
      if (c_clr) begin
        hb[c] = 0; hl[c] = 0; mflag[c] = 0; cnt_m[c] = 0;
      end else if (c_vld) begin
        hb[c] = nb; hl[c] = nl;
        if (complete) begin
          if (cnt_m[c] < cmax(c)) cnt_m[c]++;
          if (!OV[c]) begin hb[c] = 0; hl[c] = 0; end
        end
        if (MO[c]) mflag[c] = complete ? 1 : 0;
      end
    end
    q.push_back(e);
  endtask

  task automatic step_rst();
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b0; clr = 1'b0; din_vld = 1'b0; din = 1'b0;
    e = '0;
    model_reset();
    q.push_back(e);
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--)
      step(1'b0, 1'b1, bits[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input int c, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s cfg%0d t=%0t got=%0d want=%0d", nm, c, $time, act, want);
    end
  endtask

  // Monitor: decoupled from the driver, pops one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int c = 0; c < NC; c++) begin
          chk("match", c, int'(m[c]), int'(e.m[c]));
          chk("state_o", c, int'(st[c]), int'(e.s[c]));
          chk("match_cnt", c, int'(cnt[c]), int'(e.n[c]));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; din_vld = 1'b0; din = 1'b0;
    model_reset();
    step_rst();
    step_rst();
    send(32'b1101101, 7);         // overlap vs restart
    idle(3);
    step(1'b1, 1'b0, 1'b0);
    send(32'b111101, 6);          // KMP fallback
    step(1'b1, 1'b0, 1'b0);
    send(32'b1101, 4);            // Moore hold through idle
    idle(3);
    send(32'b0, 1);
    step(1'b1, 1'b0, 1'b0);
    send(32'b110, 3);             // clr beats a completing bit
    step(1'b1, 1'b1, 1'b1);
    idle(1);
    send(32'hDDDDD, 20);          // five back-to-back patterns, saturates CNT_W=2
    idle(2);
    send(32'b11, 2);              // reset mid-stream drops the prefix
    step_rst();
    send(32'b01, 2);
    send(32'b1101, 4);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0)
        step_rst();
      else
        step($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end
    idle(2);
    repeat (3) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
